// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the MUL/MLA sequencer.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] CNT_LAST = 6'd31;

   // N and Z follow the result when S is set; C and V always pass through.
   function automatic logic [3:0] flags_update(input logic [31:0] res,
                                               input logic        sflag,
                                               input logic [3:0]  nzcv_in);
      logic [3:0] f;
      f = nzcv_in;
      if (sflag) begin
         f[NZCV_N] = res[31];
         f[NZCV_Z] = (res == 32'd0);
      end
      f[NZCV_C] = nzcv_in[NZCV_C];
      f[NZCV_V] = nzcv_in[NZCV_V];
      return f;
   endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit adder with carry in/out, shared with the execute-stage datapath.
module adder32 (
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   input  logic        i_carry,
   output logic [31:0] o_result,
   output logic        o_carry
);

   assign {o_carry, o_result} = {1'b0, i_op1} + {1'b0, i_op2} + {32'd0, i_carry};

endmodule

// File: rtl/mul_seq.sv
// Radix-2 shift-add sequencer for ARMv4 MUL/MLA, one iteration per clock
// on a single shared adder32.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_accumulate,
   input  logic        i_set_flags,
   input  logic [31:0] i_rm,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rn,
   input  logic [3:0]  i_nzcv,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result,
   output logic [3:0]  o_nzcv
);

   mul_state_e       state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      mcand_q, mcand_d;
   logic [31:0]      mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       nzcv_in_q, nzcv_in_d;
   logic             sflag_q, sflag_d;
   logic [31:0]      result_q, result_d;
   logic [3:0]       nzcv_q, nzcv_d;

   logic [31:0]      add_sum;
   logic             add_carry_unused;
   logic             last_iter;

   adder32 u_adder32 (
      .i_op1    (acc_q),
      .i_op2    (mcand_q),
      .i_carry  (1'b0),
      .o_result (add_sum),
      .o_carry  (add_carry_unused)
   );

   // With early termination, stop once no set multiplier bits remain above bit 0.
   assign last_iter = (cnt_q == CNT_LAST) || (EARLY_TERM && (mplier_q[31:1] == 31'd0));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      nzcv_in_d = nzcv_in_q;
      sflag_d   = sflag_q;
      result_d  = result_q;
      nzcv_d    = nzcv_q;

      unique case (state_q)
         MUL_IDLE: begin
            if (i_start && !i_flush) begin
               acc_d     = i_accumulate ? i_rn : 32'd0;
               mcand_d   = i_rm;
               mplier_d  = i_rs;
               nzcv_in_d = i_nzcv;
               sflag_d   = i_set_flags;
               cnt_d     = '0;
               state_d   = MUL_RUN;
            end
         end
         MUL_RUN: begin
            if (i_flush) begin
               state_d = MUL_IDLE;
            end else begin
               acc_d    = mplier_q[0] ? add_sum : acc_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 6'd1;
               if (last_iter) begin
                  state_d  = MUL_DONE;
                  result_d = acc_d;
                  nzcv_d   = flags_update(acc_d, sflag_q, nzcv_in_q);
               end
            end
         end
         MUL_DONE: begin
            state_d = MUL_IDLE;
         end
         default: begin
            state_d = MUL_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= MUL_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         nzcv_in_q <= '0;
         sflag_q   <= 1'b0;
         result_q  <= '0;
         nzcv_q    <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         nzcv_in_q <= nzcv_in_d;
         sflag_q   <= sflag_d;
         result_q  <= result_d;
         nzcv_q    <= nzcv_d;
      end
   end

   assign o_busy   = (state_q != MUL_IDLE);
   // A flush arriving in DONE suppresses the pulse that same cycle.
   assign o_done   = (state_q == MUL_DONE) && !i_flush;
   assign o_result = result_q;
   assign o_nzcv   = nzcv_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench: an early-terminating and a full-length mul_seq driven in
// parallel, checked against an arithmetic reference model.
module tb_mul_seq;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_accumulate;
   logic        i_set_flags;
   logic [31:0] i_rm;
   logic [31:0] i_rs;
   logic [31:0] i_rn;
   logic [3:0]  i_nzcv;
   logic        i_flush;

   logic        busy_e, done_e, busy_f, done_f;
   logic [31:0] result_e, result_f;
   logic [3:0]  nzcv_e, nzcv_f;

   int checks = 0;
   int errors = 0;

   logic [31:0] last_res_e = '0, last_res_f = '0;
   logic [3:0]  last_nzcv_e = '0, last_nzcv_f = '0;

   mul_seq #(.EARLY_TERM(1'b1)) dut_e (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (i_start),
      .i_accumulate (i_accumulate),
      .i_set_flags  (i_set_flags),
      .i_rm         (i_rm),
      .i_rs         (i_rs),
      .i_rn         (i_rn),
      .i_nzcv       (i_nzcv),
      .i_flush      (i_flush),
      .o_busy       (busy_e),
      .o_done       (done_e),
      .o_result     (result_e),
      .o_nzcv       (nzcv_e)
   );

   mul_seq #(.EARLY_TERM(1'b0)) dut_f (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (i_start),
      .i_accumulate (i_accumulate),
      .i_set_flags  (i_set_flags),
      .i_rm         (i_rm),
      .i_rs         (i_rs),
      .i_rn         (i_rn),
      .i_nzcv       (i_nzcv),
      .i_flush      (i_flush),
      .o_busy       (busy_f),
      .o_done       (done_f),
      .o_result     (result_f),
      .o_nzcv       (nzcv_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_iters(input logic [31:0] rs, input bit early);
      if (!early) return 32;
      for (int i = 31; i >= 0; i--) begin
         if (rs[i]) return i + 1;
      end
      return 1;
   endfunction

   function automatic logic [31:0] model_result(input logic [31:0] rm, input logic [31:0] rs,
                                                input logic [31:0] rn, input logic acc);
      longint unsigned p;
      p = longint'(rm) * longint'(rs);
      return 32'(p) + (acc ? rn : 32'd0);
   endfunction

   function automatic logic [3:0] model_flags(input logic [31:0] res, input logic s,
                                              input logic [3:0] nzcv);
      return s ? {res[31], (res == 32'd0), nzcv[1], nzcv[0]} : nzcv;
   endfunction

   task automatic scramble_inputs();
      i_rm         = $urandom;
      i_rs         = $urandom;
      i_rn         = $urandom;
      i_accumulate = 1'($urandom);
      i_set_flags  = 1'($urandom);
      i_nzcv       = 4'($urandom);
   endtask

   // Latency is reported as "done at T+n": o_done seen after edge T+k is sampled at T+k+1.
   task automatic do_op(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                        input logic acc, input logic s, input logic [3:0] nzcv,
                        input int busy_k, input string name);
      logic [31:0] exp_res;
      logic [3:0]  exp_nzcv;
      int exp_lat_e, lat_e, lat_f, pulses_e, pulses_f;
      exp_res   = model_result(rm, rs, rn, acc);
      exp_nzcv  = model_flags(exp_res, s, nzcv);
      exp_lat_e = model_iters(rs, 1'b1) + 1;
      lat_e = 0; lat_f = 0; pulses_e = 0; pulses_f = 0;
      @(negedge clk);
      i_start = 1'b1; i_rm = rm; i_rs = rs; i_rn = rn;
      i_accumulate = acc; i_set_flags = s; i_nzcv = nzcv;
      @(negedge clk);
      i_start = 1'b0;
      scramble_inputs();
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == busy_k) begin
            i_start = 1'b1;
            scramble_inputs();
         end else begin
            i_start = 1'b0;
         end
         if (k == 1) begin
            checks++;
            if (busy_e !== 1'b1 || busy_f !== 1'b1) begin
               errors++;
               $display("FAIL %s busy: got e=%b f=%b want 1", name, busy_e, busy_f);
            end
         end
         if (done_e === 1'b1) begin
            pulses_e++;
            if (lat_e == 0) lat_e = k + 1;
         end
         if (done_f === 1'b1) begin
            pulses_f++;
            if (lat_f == 0) lat_f = k + 1;
         end
      end
      i_start = 1'b0;
      checks++;
      if (pulses_e != 1 || pulses_f != 1) begin
         errors++;
         $display("FAIL %s pulses: got e=%0d f=%0d want 1", name, pulses_e, pulses_f);
      end
      checks++;
      if (lat_e != exp_lat_e) begin
         errors++;
         $display("FAIL %s latency_early: got T+%0d want T+%0d", name, lat_e, exp_lat_e);
      end
      checks++;
      if (lat_f != 33) begin
         errors++;
         $display("FAIL %s latency_full: got T+%0d want T+33", name, lat_f);
      end
      checks++;
      if (result_e !== exp_res || result_f !== exp_res) begin
         errors++;
         $display("FAIL %s result: got e=%h f=%h want %h", name, result_e, result_f, exp_res);
      end
      checks++;
      if (nzcv_e !== exp_nzcv || nzcv_f !== exp_nzcv) begin
         errors++;
         $display("FAIL %s nzcv: got e=%b f=%b want %b", name, nzcv_e, nzcv_f, exp_nzcv);
      end
      last_res_e = exp_res; last_res_f = exp_res;
      last_nzcv_e = exp_nzcv; last_nzcv_f = exp_nzcv;
   endtask

   task automatic check_zero_outputs(input string name);
      checks++;
      if (busy_e !== 1'b0 || busy_f !== 1'b0 || done_e !== 1'b0 || done_f !== 1'b0 ||
          result_e !== 32'd0 || result_f !== 32'd0 || nzcv_e !== 4'd0 || nzcv_f !== 4'd0) begin
         errors++;
         $display("FAIL %s: got busy=%b%b done=%b%b res=%h/%h nzcv=%b/%b want all 0", name,
                  busy_e, busy_f, done_e, done_f, result_e, result_f, nzcv_e, nzcv_f);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_start = 1'b0; i_flush = 1'b0;
      scramble_inputs();
      #12;
      check_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      do_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0011, 0, "mul_7x6");
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 4'b1111, 0, "mla_wrap");
      do_op(32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b1, 4'b1010, 0, "zero_s1");
      do_op(32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0, 4'b1010, 0, "zero_s0");
      do_op(32'd3, 32'd2, 32'd0, 1'b0, 1'b0, 4'b0000, 0, "mul_3x2");
      do_op(32'd9, 32'd1, 32'h8000_0000, 1'b1, 1'b1, 4'b0101, 0, "mla_neg");
   endtask

   task automatic test_random();
      logic [31:0] rs;
      for (int n = 0; n < 25; n++) begin
         rs = $urandom >> $urandom_range(0, 31);
         if (n % 7 == 0) rs = 32'd0;
         do_op($urandom, rs, $urandom, 1'($urandom), 1'($urandom), 4'($urandom), 0, "random");
      end
   endtask

   task automatic test_start_while_busy();
      do_op(32'd5, 32'h00F0_0000, 32'd11, 1'b1, 1'b1, 4'b0010, 4, "start_busy");
   endtask

   task automatic test_flush_run();
      int pulses;
      pulses = 0;
      @(negedge clk);
      i_start = 1'b1; i_rm = 32'hFFFF_FFFF; i_rs = 32'hFFFF_FFFF; i_rn = 32'd0;
      i_accumulate = 1'b0; i_set_flags = 1'b1; i_nzcv = 4'b1111;
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 9) i_flush = 1'b1;
         if (k == 10) begin
            i_flush = 1'b0;
            checks++;
            if (busy_e !== 1'b0 || busy_f !== 1'b0) begin
               errors++;
               $display("FAIL flush_run idle: got busy e=%b f=%b want 0", busy_e, busy_f);
            end
         end
         if (done_e === 1'b1 || done_f === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL flush_run pulses: got %0d want 0", pulses);
      end
      checks++;
      if (result_e !== last_res_e || result_f !== last_res_f ||
          nzcv_e !== last_nzcv_e || nzcv_f !== last_nzcv_f) begin
         errors++;
         $display("FAIL flush_run hold: got %h/%h %b/%b want %h/%h %b/%b", result_e, result_f,
                  nzcv_e, nzcv_f, last_res_e, last_res_f, last_nzcv_e, last_nzcv_f);
      end
   endtask

   task automatic test_flush_done();
      int pulses;
      pulses = 0;
      @(negedge clk);
      i_start = 1'b1; i_rm = 32'd5; i_rs = 32'd0; i_rn = 32'd0;
      i_accumulate = 1'b0; i_set_flags = 1'b0; i_nzcv = 4'b1001;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      checks++;
      if (done_e !== 1'b1) begin
         errors++;
         $display("FAIL flush_done pre: got done_e=%b want 1", done_e);
      end
      i_flush = 1'b1;
      #1;
      checks++;
      if (done_e !== 1'b0) begin
         errors++;
         $display("FAIL flush_done forced_low: got done_e=%b want 0", done_e);
      end
      @(negedge clk);
      i_flush = 1'b0;
      checks++;
      if (busy_e !== 1'b0 || busy_f !== 1'b0) begin
         errors++;
         $display("FAIL flush_done idle: got busy e=%b f=%b want 0", busy_e, busy_f);
      end
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         if (done_e === 1'b1 || done_f === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL flush_done pulses: got %0d want 0", pulses);
      end
      // The early unit already latched its result on entering DONE.
      last_res_e = 32'd0; last_nzcv_e = 4'b1001;
      checks++;
      if (result_e !== last_res_e || nzcv_e !== last_nzcv_e ||
          result_f !== last_res_f || nzcv_f !== last_nzcv_f) begin
         errors++;
         $display("FAIL flush_done hold: got %h/%h %b/%b want %h/%h %b/%b", result_e, result_f,
                  nzcv_e, nzcv_f, last_res_e, last_res_f, last_nzcv_e, last_nzcv_f);
      end
   endtask

   task automatic test_flush_priority();
      @(negedge clk);
      i_start = 1'b1; i_flush = 1'b1; i_rs = 32'd3;
      @(negedge clk);
      i_start = 1'b0; i_flush = 1'b0;
      checks++;
      if (busy_e !== 1'b0 || busy_f !== 1'b0) begin
         errors++;
         $display("FAIL flush_priority: got busy e=%b f=%b want 0", busy_e, busy_f);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      i_start = 1'b1; i_rm = 32'hDEAD_BEEF; i_rs = 32'hFFFF_FFFF;
      i_accumulate = 1'b0; i_set_flags = 1'b1; i_nzcv = 4'b0011;
      @(negedge clk);
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("reset_mid_run");
      @(negedge clk);
      rst = 1'b0;
      last_res_e = '0; last_res_f = '0; last_nzcv_e = '0; last_nzcv_f = '0;
      do_op(32'd1000, 32'd1000, 32'd0, 1'b0, 1'b1, 4'b1100, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_flush_run();
      test_flush_done();
      test_flush_priority();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
